// File: rtl/apb_rmw_master.sv
// apb_rmw_master: APB3 master that serialises register operations from N_REQ
// requestors. Supports READ, WRITE and atomic SET/CLR read-modify-write with
// round-robin arbitration, slave-error reporting and a wait-state timeout.
module apb_rmw_master #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [2*N_REQ-1:0]        req_op_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic [1:0]                rsp_err_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic [DATA_W-1:0]         pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [DATA_W-1:0]         prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_SLV  = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        R_SETUP,
        R_ACCESS,
        W_SETUP,
        W_ACCESS,
        RESP
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [31:0]        tcount;
    logic [1:0]         cur_op;
    logic [DATA_W-1:0]  cur_data;
    logic [ID_W-1:0]    cur_id;
    logic [DATA_W-1:0]  rd_value;

    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand;
    logic [1:0]         grant_op;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_data;
    logic [ID_W-1:0]    next_ptr;
    logic               timeout_hit;

    // Round-robin search starting at the pointer, wrapping, picks the first valid requestor
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        grant_op    = '0;
        grant_addr  = '0;
        grant_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
                grant_op    = req_op_i[2*cand +: 2];
                grant_addr  = req_addr_i[cand*ADDR_W +: ADDR_W];
                grant_data  = req_data_i[cand*DATA_W +: DATA_W];
            end
        end
    end

    // Accept pulse goes only to the winner and only while idle and out of reset
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && rst_ni && grant_found) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    // Pointer moves to the requestor after the winner; abort fires on the last allowed wait cycle
    always_comb begin
        next_ptr    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        timeout_hit = (TIMEOUT != 0) && !pready_i && (tcount == TO_LAST);
    end

    // Main transfer FSM; all bus and response outputs are registered here
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            tcount      <= '0;
            cur_op      <= '0;
            cur_data    <= '0;
            cur_id      <= '0;
            rd_value    <= '0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pwrite_o    <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        cur_op    <= grant_op;
                        cur_data  <= grant_data;
                        cur_id    <= grant_id;
                        rr_ptr    <= next_ptr;
                        paddr_o   <= grant_addr;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        if (grant_op == OP_WRITE) begin
                            pwrite_o <= 1'b1;
                            pwdata_o <= grant_data;
                            state    <= W_SETUP;
                        end else begin
                            pwrite_o <= 1'b0;
                            pwdata_o <= '0;
                            state    <= R_SETUP;
                        end
                    end
                end
                R_SETUP: begin
                    penable_o <= 1'b1;
                    tcount    <= '0;
                    state     <= R_ACCESS;
                end
                R_ACCESS: begin
                    if (pready_i) begin
                        rd_value <= prdata_i;
                        if (pslverr_i || cur_op == OP_READ) begin
                            psel_o      <= 1'b0;
                            penable_o   <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            rsp_id_o    <= cur_id;
                            rsp_rdata_o <= prdata_i;
                            rsp_err_o   <= pslverr_i ? ERR_SLV : ERR_OK;
                            state       <= RESP;
                        end else begin
                            penable_o <= 1'b0;
                            pwrite_o  <= 1'b1;
                            pwdata_o  <= (cur_op == OP_SET) ? (prdata_i | cur_data)
                                                            : (prdata_i & ~cur_data);
                            state     <= W_SETUP;
                        end
                    end else if (timeout_hit) begin
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_id_o    <= cur_id;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= ERR_TO;
                        state       <= RESP;
                    end else begin
                        tcount <= tcount + 32'd1;
                    end
                end
                W_SETUP: begin
                    penable_o <= 1'b1;
                    tcount    <= '0;
                    state     <= W_ACCESS;
                end
                W_ACCESS: begin
                    if (pready_i) begin
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_id_o    <= cur_id;
                        rsp_rdata_o <= (cur_op == OP_WRITE) ? '0 : rd_value;
                        rsp_err_o   <= pslverr_i ? ERR_SLV : ERR_OK;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_id_o    <= cur_id;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= ERR_TO;
                        state       <= RESP;
                    end else begin
                        tcount <= tcount + 32'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rmw_master.sv
// tb_apb_rmw_master: randomized scoreboard bench for apb_rmw_master with an
// APB slave memory model, a round-robin reference and an op-level reference.
module tb_apb_rmw_master;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 8;
    localparam int IDW = 2;

    logic              clk;
    logic              rst_ni;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [2*N-1:0]    req_op_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*DW-1:0]   req_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [IDW-1:0]    rsp_id_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic [1:0]        rsp_err_o;
    logic [AW-1:0]     paddr_o;
    logic [DW-1:0]     pwdata_o;
    logic              pwrite_o;
    logic              psel_o;
    logic              penable_o;
    logic [DW-1:0]     prdata_i;
    logic              pready_i;
    logic              pslverr_i;

    apb_rmw_master #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
        .psel_o(psel_o), .penable_o(penable_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          xfers;
        int          acc;
        int          lat;
        int          idx;
        bit          wr;
        logic [31:0] newval;
        int          grant_cyc;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    logic [31:0] smem [0:63];
    logic [31:0] rmem [0:63];
    bit   [N-1:0] granted;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int rr_ptr = 0;
    int cfg_max_wait = 0;
    int cfg_stall = 0;
    int xfers = 0;
    int acc_cycles = 0;
    int first_psel = -1;
    int first_pen = -1;
    int proto_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit is_rderr(input int idx);
        return (idx == 6) || (idx == 60);
    endfunction

    function automatic bit is_wrerr(input int idx);
        return idx == 61;
    endfunction

    function automatic bit is_to(input int idx);
        return idx == 62;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, "_psel"}, 32'(psel_o), 0);
        checkOutput({tag, "_penable"}, 32'(penable_o), 0);
        checkOutput({tag, "_pwrite"}, 32'(pwrite_o), 0);
        checkOutput({tag, "_paddr"}, paddr_o, 0);
        checkOutput({tag, "_pwdata"}, pwdata_o, 0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err_o), 0);
        checkOutput({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
        checkOutput({tag, "_rsp_id"}, 32'(rsp_id_o), 0);
        checkOutput({tag, "_req_ready"}, 32'(req_ready_o), 0);
    endtask

    task automatic setReq(input int i, input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        req_op_i[2*i +: 2]     = op;
        req_addr_i[i*AW +: AW] = addr;
        req_data_i[i*DW +: DW] = data;
        req_valid_i[i]         = 1'b1;
    endtask

    task automatic randReq(input int i);
        int idx;
        logic [31:0] r;
        logic [1:0] op;
        idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 62)) : int'($urandom_range(0, 15));
        r   = $urandom();
        op  = 2'($urandom_range(0, 3));
        setReq(i, op, {r[31:8], idx[5:0], 2'b00}, $urandom());
    endtask

    // Grant watcher: checks the round-robin winner and pushes the expected response
    initial begin
        int w;
        int idx;
        logic [1:0] op;
        logic [31:0] data;
        logic [31:0] old;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni && req_ready_o != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req_valid_i[(rr_ptr + k) % N]) w = (rr_ptr + k) % N;
                end
                checkOutput("grant", 32'(req_ready_o), (w >= 0) ? (32'd1 << w) : 32'd0);
                if (w >= 0) begin
                    rr_ptr = (w + 1) % N;
                    granted[w] = 1'b1;
                    grant_log.push_back(w);
                    op   = req_op_i[2*w +: 2];
                    idx  = int'(req_addr_i[w*AW + 2 +: 6]);
                    data = req_data_i[w*DW +: DW];
                    old  = rmem[idx];
                    e.id = w; e.idx = idx; e.wr = 1'b0; e.newval = '0;
                    e.acc = -1; e.lat = -1; e.grant_cyc = cyc;
                    if (is_to(idx)) begin
                        e.rdata = 0; e.err = 2'b10; e.xfers = 0; e.acc = TO;
                    end else if (op == 2'b00) begin
                        e.rdata = old; e.err = is_rderr(idx) ? 2'b01 : 2'b00; e.xfers = 1; e.lat = 3;
                    end else if (op == 2'b01) begin
                        e.rdata = 0; e.xfers = 1; e.lat = 3;
                        e.err = is_wrerr(idx) ? 2'b01 : 2'b00;
                        e.wr = !is_wrerr(idx); e.newval = data;
                    end else if (is_rderr(idx)) begin
                        e.rdata = old; e.err = 2'b01; e.xfers = 1; e.lat = 3;
                    end else begin
                        e.rdata = old; e.xfers = 2; e.lat = 5;
                        e.err = is_wrerr(idx) ? 2'b01 : 2'b00;
                        e.wr = !is_wrerr(idx);
                        e.newval = (op == 2'b10) ? (old | data) : (old & ~data);
                    end
                    if (cfg_max_wait != 0) e.lat = -1;
                    xfers = 0; acc_cycles = 0; first_psel = -1; first_pen = -1;
                    sb.push_back(e);
                end
            end
        end
    end

    // Response monitor: drives rsp_ready, checks hold-while-stalled and scores each response
    initial begin
        int stall;
        bit held;
        bit seen;
        int first_cyc;
        bit go;
        logic [IDW-1:0] h_id;
        logic [31:0] h_rdata;
        logic [1:0] h_err;
        exp_t e;
        stall = 0; held = 0; seen = 0; first_cyc = 0;
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                rsp_ready_i = 1'b0; stall = 0; held = 0; seen = 0;
            end else if (rsp_valid_o) begin
                if (!seen) begin
                    seen = 1; first_cyc = cyc;
                end
                if (held) begin
                    checkOutput("hold_id", 32'(rsp_id_o), 32'(h_id));
                    checkOutput("hold_rdata", rsp_rdata_o, h_rdata);
                    checkOutput("hold_err", 32'(rsp_err_o), 32'(h_err));
                end
                go = (cfg_stall < 0) ? bit'($urandom_range(0, 1)) : (stall >= cfg_stall);
                if (go) begin
                    rsp_ready_i = 1'b1;
                    stall = 0; held = 0; seen = 0;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("rsp_id", 32'(rsp_id_o), 32'(e.id));
                        checkOutput("rsp_rdata", rsp_rdata_o, e.rdata);
                        checkOutput("rsp_err", 32'(rsp_err_o), 32'(e.err));
                        checkOutput("apb_xfers", 32'(xfers), 32'(e.xfers));
                        if (e.acc >= 0) checkOutput("timeout_access_cycles", 32'(acc_cycles), 32'(e.acc));
                        if (e.lat >= 0) begin
                            checkOutput("rsp_latency", 32'(first_cyc - e.grant_cyc), 32'(e.lat));
                            checkOutput("psel_cycle", 32'(first_psel - e.grant_cyc), 1);
                            checkOutput("penable_cycle", 32'(first_pen - e.grant_cyc), 2);
                        end
                        if (e.wr) rmem[e.idx] = e.newval;
                    end
                end else begin
                    rsp_ready_i = 1'b0;
                    stall++; held = 1;
                    h_id = rsp_id_o; h_rdata = rsp_rdata_o; h_err = rsp_err_o;
                end
            end else begin
                if (held) checkOutput("hold_valid", 32'(rsp_valid_o), 1);
                rsp_ready_i = 1'b0; held = 0;
            end
        end
    end

    // APB slave model: random wait states, error and never-ready addresses
    initial begin
        int wait_left;
        int idx;
        logic [31:0] setup_addr;
        wait_left = 0; setup_addr = '0;
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
        forever begin
            @(negedge clk);
            idx = int'(paddr_o[7:2]);
            if (!rst_ni) begin
                pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
            end else if (psel_o && !penable_o) begin
                pready_i = 1'b0;
                wait_left = (cfg_max_wait > 0) ? int'($urandom_range(0, cfg_max_wait)) : 0;
                setup_addr = paddr_o;
                if (first_psel < 0) first_psel = cyc;
            end else if (psel_o && penable_o) begin
                acc_cycles++;
                if (first_pen < 0) first_pen = cyc;
                if (paddr_o != setup_addr) proto_err++;
                if (!pwrite_o && pwdata_o != '0) proto_err++;
                if (is_to(idx)) begin
                    pready_i = 1'b0;
                end else if (wait_left > 0) begin
                    pready_i = 1'b0; wait_left--;
                end else begin
                    pready_i  = 1'b1;
                    prdata_i  = smem[idx];
                    pslverr_i = pwrite_o ? is_wrerr(idx) : is_rderr(idx);
                end
            end else begin
                pready_i = 1'b0; pslverr_i = 1'b0;
            end
        end
    end

    // Slave commit on completed transfers
    initial forever begin
        @(posedge clk);
        if (rst_ni && psel_o && penable_o && pready_i) begin
            xfers++;
            if (pwrite_o && !is_wrerr(int'(paddr_o[7:2]))) smem[paddr_o[7:2]] = pwdata_o;
        end
    end

    task automatic applyStimulus(input int i, input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        int budget;
        @(posedge clk); #1;
        setReq(i, op, addr, data);
        budget = 0;
        while (!granted[i] && budget < 200) begin
            @(posedge clk); #1; budget++;
        end
        checkOutput("grant_seen", 32'(granted[i]), 1);
        granted[i] = 1'b0;
        req_valid_i[i] = 1'b0;
        budget = 0;
        while (sb.size() != 0 && budget < 300) begin
            @(posedge clk); #1; budget++;
        end
        checkOutput("drain", 32'(sb.size()), 0);
    endtask

    task automatic runRandom(input int n, input bit all_valid);
        int presented;
        int budget;
        presented = 0;
        if (all_valid) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) randReq(i);
            presented = N;
        end
        budget = 0;
        while (budget < 8000) begin
            @(posedge clk); #1; budget++;
            for (int i = 0; i < N; i++) begin
                if (granted[i]) begin
                    granted[i] = 1'b0;
                    req_valid_i[i] = 1'b0;
                    if (all_valid && presented < n) begin
                        randReq(i); presented++;
                    end
                end
                if (!all_valid && !req_valid_i[i] && presented < n && $urandom_range(0, 3) == 0) begin
                    randReq(i); presented++;
                end
            end
            if (presented == n && req_valid_i == '0 && sb.size() == 0 && !rsp_valid_o) break;
        end
        checkOutput("random_drain", 32'(budget < 8000), 1);
    endtask

    initial begin
        int budget;
        bit found;
        for (int k = 0; k < 64; k++) begin
            smem[k] = '0; rmem[k] = '0;
        end
        granted = '0;
        rst_ni = 1'b0;
        req_valid_i = '0; req_op_i = '0; req_addr_i = '0; req_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleBus("reset");
        @(posedge clk); #1;
        rst_ni = 1'b1;

        $display("[TB] directed WRITE");
        cfg_max_wait = 0; cfg_stall = 0;
        applyStimulus(0, 2'b01, 32'h1A102024, 32'h00100307);
        checkOutput("write_mem", smem[9], 32'h00100307);

        $display("[TB] directed SET");
        smem[0] = 32'h3; rmem[0] = 32'h3;
        applyStimulus(1, 2'b10, 32'h0, 32'h4);
        checkOutput("set_pwdata", smem[0], 32'h7);

        $display("[TB] directed CLR with read error");
        smem[6] = 32'hFF; rmem[6] = 32'hFF;
        applyStimulus(2, 2'b11, 32'h18, 32'h10);
        checkOutput("clr_err_mem", smem[6], 32'hFF);

        $display("[TB] directed READ timeout");
        applyStimulus(3, 2'b00, 32'hF8, 32'h0);

        $display("[TB] random traffic, zero wait");
        runRandom(20, 1'b0);
        $display("[TB] random traffic, wait states and random stalls");
        cfg_max_wait = 2; cfg_stall = -1;
        runRandom(40, 1'b0);

        $display("[TB] reset during write access of SET");
        cfg_max_wait = 0; cfg_stall = 0;
        @(posedge clk); #1;
        setReq(1, 2'b10, 32'h40, 32'h5);
        found = 0; budget = 0;
        while (!found && budget < 50) begin
            @(negedge clk); budget++;
            if (psel_o && penable_o && pwrite_o) found = 1;
        end
        checkOutput("wacc_reached", 32'(found), 1);
        rst_ni = 1'b0;
        req_valid_i = '0; granted = '0;
        sb.delete(); rr_ptr = 0;
        @(negedge clk);
        checkIdleBus("rst_mid");
        @(posedge clk); #1;
        rst_ni = 1'b1;

        $display("[TB] all requestors valid, stalled responses");
        cfg_stall = 5;
        grant_log.delete();
        runRandom(5, 1'b1);
        checkOutput("rr_count", 32'(grant_log.size()), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            checkOutput("rr_order", 32'(grant_log[k]), 32'(k % 4));
        end

        for (int k = 0; k < 64; k++) checkOutput("mem_final", smem[k], rmem[k]);
        checkOutput("protocol", 32'(proto_err), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
